// File: rtl/param_cacheline_adaptor_pkg.sv
// Shared definitions for the cacheline adaptor slice:
//   - state_t        : adaptor FSM states (IDLE/READ/WRITE/DONE)
//   - *_DEF          : default line, burst and address widths
//   - offset_bits()  : number of byte-offset bits inside one cacheline
package param_cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LINE_WIDTH_DEF  = 256;
  localparam int BURST_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF  = 32;

  // Byte-offset bits within a line; these are zeroed to line-align an address.
  function automatic int offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/param_cacheline_adaptor_counter.sv
// burst_beat_counter: beat index within one cacheline transfer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : advance to the next beat
//   clr        : return to beat 0 (has priority over en)
//   count      : current beat index, $clog2(BEATS) bits
//   last       : high while count addresses the final beat
module burst_beat_counter
  import param_cacheline_adaptor_pkg::*;
#(
  parameter int BEATS = LINE_WIDTH_DEF / BURST_WIDTH_DEF,
  parameter int CW    = $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/param_cacheline_adaptor.sv
// param_cacheline_adaptor: bridges one LINE_WIDTH cacheline transfer from the
// LLC into LINE_WIDTH/BURST_WIDTH sequential memory beats (fill or write-back).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   line_i / line_o       : write-back line from LLC / filled line to LLC
//   address_i             : LLC byte address
//   read_i / write_i      : LLC fill / write-back request (read wins if both)
//   resp_o                : one-cycle completion pulse to LLC
//   burst_i / burst_o     : read beat from memory / write beat to memory
//   address_o             : line-aligned memory address
//   read_o / write_o      : memory read / write request
//   resp_i                : memory beat acknowledge, one beat per high cycle
module param_cacheline_adaptor
  import param_cacheline_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int BURST_WIDTH = BURST_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam int OFF   = offset_bits(LINE_WIDTH);

  state_t                  state;
  logic [LINE_WIDTH-1:0]   wbuf;
  logic [CW-1:0]           beat;
  logic                    beat_last;
  logic                    beat_en;
  logic                    beat_clr;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  int                      beat_base;

  assign aligned_addr = {address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign beat_base    = int'(beat) * BURST_WIDTH;

  // The counter stops on the last beat so it never wraps mid-transfer;
  // DONE returns it to 0 for the next request.
  assign beat_en  = ((state == READ) || (state == WRITE)) && resp_i && !beat_last;
  assign beat_clr = (state == DONE);

  burst_beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .en    (beat_en),
    .clr   (beat_clr),
    .count (beat),
    .last  (beat_last)
  );

  // Decoded from the buffered line and the registered beat index only, so the
  // beat changes solely on the edge after an accepted resp_i.
  assign burst_o = (state == WRITE) ? wbuf[beat_base +: BURST_WIDTH] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      wbuf      <= '0;
      line_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          if (read_i) begin
            address_o <= aligned_addr;
            read_o    <= 1'b1;
            state     <= READ;
          end else if (write_i) begin
            address_o <= aligned_addr;
            wbuf      <= line_i;
            write_o   <= 1'b1;
            state     <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[beat_base +: BURST_WIDTH] <= burst_i;
            if (beat_last) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i && beat_last) begin
            write_o <= 1'b0;
            resp_o  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cacheline_adaptor.sv
module tb_param_cacheline_adaptor;

  localparam int LW  = 256;
  localparam int BW  = 64;
  localparam int AW  = 32;
  localparam int WLW = 512;
  localparam int WBW = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [LW-1:0] line_i = '0, line_o;
  logic [AW-1:0] address_i = '0, address_o;
  logic          read_i = 1'b0, write_i = 1'b0, resp_o;
  logic [BW-1:0] burst_i = '0, burst_o;
  logic          read_o, write_o, resp_i = 1'b0;

  logic [WLW-1:0] w_line_i = '0, w_line_o;
  logic [AW-1:0]  w_address_i = '0, w_address_o;
  logic           w_read_i = 1'b0, w_write_i = 1'b0, w_resp_o;
  logic [WBW-1:0] w_burst_i = '0, w_burst_o;
  logic           w_read_o, w_write_o, w_resp_i = 1'b0;

  param_cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i),
    .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  param_cacheline_adaptor #(.LINE_WIDTH(WLW), .BURST_WIDTH(WBW), .ADDR_WIDTH(AW)) dut_wide (
    .clk(clk), .reset(reset), .line_i(w_line_i), .line_o(w_line_o), .address_i(w_address_i),
    .read_i(w_read_i), .write_i(w_write_i), .resp_o(w_resp_o), .burst_i(w_burst_i),
    .burst_o(w_burst_o), .address_o(w_address_o), .read_o(w_read_o), .write_o(w_write_o),
    .resp_i(w_resp_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int w_resp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (resp_o === 1'b1) resp_cnt <= resp_cnt + 1;
    if (w_resp_o === 1'b1) w_resp_cnt <= w_resp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [BW-1:0] A0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [BW-1:0] A1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [BW-1:0] A2 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [BW-1:0] A3 = 64'hCAFE_F00D_5555_AAAA;
  localparam logic [BW-1:0] D0 = 64'h1111_0000_0000_1111;
  localparam logic [BW-1:0] D1 = 64'h2222_0000_0000_2222;
  localparam logic [BW-1:0] D2 = 64'h3333_0000_0000_3333;
  localparam logic [BW-1:0] D3 = 64'h4444_0000_0000_4444;

  // Drives one fill on the default instance with the given resp_i pattern.
  // lat is counted so that a request at edge 0 with no stalls gives 5.
  task automatic drive_read(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                            input logic [15:0] pat, input int n,
                            output int lat, output int pulses, output bit held,
                            output logic rd_in_done);
    int k, req, c0;
    @(negedge clk);
    address_i = addr; read_i = 1'b1; write_i = 1'b0;
    @(posedge clk); #1;
    read_i = 1'b0; req = cyc; c0 = resp_cnt; held = 1'b1; k = 0;
    for (int i = 0; i < n; i++) begin
      resp_i  = pat[i];
      burst_i = line[k*BW +: BW];
      @(negedge clk);
      if (read_o !== 1'b1) held = 1'b0;
      @(posedge clk); #1;
      if (pat[i]) k++;
    end
    resp_i = 1'b0; burst_i = '0;
    @(negedge clk);
    lat = (resp_o === 1'b1) ? (cyc - req + 1) : -1;
    rd_in_done = read_o;
    @(posedge clk); #2;
    pulses = resp_cnt - c0;
  endtask

  task automatic drive_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                             input logic [15:0] pat, input int n,
                             output int lat, output int pulses, output int wcycles,
                             output int bad, output logic [BW-1:0] badval);
    int k, req, c0;
    @(negedge clk);
    address_i = addr; line_i = line; write_i = 1'b1; read_i = 1'b0;
    @(posedge clk); #1;
    write_i = 1'b0; line_i = '0; req = cyc; c0 = resp_cnt; k = 0;
    wcycles = 0; bad = 0; badval = '0;
    for (int i = 0; i < n; i++) begin
      resp_i = pat[i];
      @(negedge clk);
      if (write_o === 1'b1) wcycles++;
      if (burst_o !== line[k*BW +: BW]) begin bad++; badval = burst_o; end
      @(posedge clk); #1;
      if (pat[i]) k++;
    end
    resp_i = 1'b0;
    @(negedge clk);
    lat = (resp_o === 1'b1) ? (cyc - req + 1) : -1;
    @(posedge clk); #2;
    pulses = resp_cnt - c0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (read_o !== 1'b0)  begin n_bad++; $display("FAIL reset_read_o got %b want 0", read_o); end
    n_cmp++; if (write_o !== 1'b0) begin n_bad++; $display("FAIL reset_write_o got %b want 0", write_o); end
    n_cmp++; if (resp_o !== 1'b0)  begin n_bad++; $display("FAIL reset_resp_o got %b want 0", resp_o); end
    n_cmp++; if (address_o !== '0) begin n_bad++; $display("FAIL reset_address_o got %h want 0", address_o); end
    n_cmp++; if (burst_o !== '0)   begin n_bad++; $display("FAIL reset_burst_o got %h want 0", burst_o); end
    n_cmp++; if (line_o !== '0)    begin n_bad++; $display("FAIL reset_line_o got %h want 0", line_o); end
    n_cmp++; if (w_line_o !== '0)  begin n_bad++; $display("FAIL reset_wide_line_o got %h want 0", w_line_o); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read_basic();
    int lat, pulses; bit held; logic rd_done;
    drive_read(32'h1234_5678, {A3, A2, A1, A0}, 16'h000F, 4, lat, pulses, held, rd_done);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL read_latency got %0d want 5", lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL read_pulses got %0d want 1", pulses); end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL read_o_held got %b want 1", held); end
    n_cmp++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL read_o_in_done got %b want 0", rd_done); end
    n_cmp++; if (address_o !== 32'h1234_5660) begin n_bad++; $display("FAIL read_address got %h want 12345660", address_o); end
    n_cmp++; if (line_o !== {A3, A2, A1, A0}) begin n_bad++; $display("FAIL read_line got %h want %h", line_o, {A3, A2, A1, A0}); end
  endtask

  task automatic test_write_basic();
    int lat, pulses, wcyc, bad; logic [BW-1:0] bv;
    drive_write(32'h0000_ABCD, {D3, D2, D1, D0}, 16'h000F, 4, lat, pulses, wcyc, bad, bv);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL write_burst_order bad=%0d last got %h", bad, bv); end
    n_cmp++; if (wcyc !== 4) begin n_bad++; $display("FAIL write_o_cycles got %0d want 4", wcyc); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL write_latency got %0d want 5", lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL write_pulses got %0d want 1", pulses); end
    n_cmp++; if (address_o !== 32'h0000_ABC0) begin n_bad++; $display("FAIL write_address got %h want 0000abc0", address_o); end
    n_cmp++; if (write_o !== 1'b0) begin n_bad++; $display("FAIL write_o_after got %b want 0", write_o); end
  endtask

  task automatic test_stalled_read();
    int lat, pulses; bit held; logic rd_done;
    // pattern 1,0,0,1,1,0,1 (bit 0 first)
    drive_read(32'h0000_0100, {D0, A1, D2, A3}, 16'b1011001, 7, lat, pulses, held, rd_done);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL stall_latency got %0d want 8", lat); end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL stall_read_o_held got %b want 1", held); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL stall_pulses got %0d want 1", pulses); end
    n_cmp++; if (line_o !== {D0, A1, D2, A3}) begin n_bad++; $display("FAIL stall_line got %h want %h", line_o, {D0, A1, D2, A3}); end
  endtask

  task automatic test_stalled_write();
    int lat, pulses, wcyc, bad; logic [BW-1:0] bv;
    drive_write(32'h0000_0200, {A0, D1, A2, D3}, 16'b110101, 6, lat, pulses, wcyc, bad, bv);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_write_burst bad=%0d last got %h", bad, bv); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL stall_write_latency got %0d want 7", lat); end
  endtask

  task automatic test_read_write_together();
    int c0, wr_seen, rd_seen; logic [LW-1:0] la;
    la = {A0, A1, A2, A3};
    @(negedge clk);
    address_i = 32'h0000_0040; read_i = 1'b1; write_i = 1'b1; line_i = {D3, D2, D1, D0};
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0; line_i = '0; c0 = resp_cnt; wr_seen = 0; rd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = la[i*BW +: BW];
      @(negedge clk);
      if (write_o !== 1'b0) wr_seen++;
      if (read_o === 1'b1) rd_seen++;
      @(posedge clk); #1;
    end
    resp_i = 1'b0; burst_i = '0;
    // resp_i while idle after DONE must not start anything
    @(posedge clk); #1; resp_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_resp_ignored got rd=%b wr=%b resp=%b want 0 0 0", read_o, write_o, resp_o);
    end
    resp_i = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if (wr_seen !== 0) begin n_bad++; $display("FAIL both_write_o got %0d cycles want 0", wr_seen); end
    n_cmp++; if (rd_seen !== 4) begin n_bad++; $display("FAIL both_read_o got %0d cycles want 4", rd_seen); end
    n_cmp++; if ((resp_cnt - c0) !== 1) begin n_bad++; $display("FAIL both_pulses got %0d want 1", resp_cnt - c0); end
    n_cmp++; if (address_o !== 32'h0000_0040) begin n_bad++; $display("FAIL both_address got %h want 00000040", address_o); end
    n_cmp++; if (line_o !== la) begin n_bad++; $display("FAIL both_line got %h want %h", line_o, la); end
  endtask

  task automatic test_reset_mid_write();
    int c0, lat, pulses; bit held; logic rd_done; logic [LW-1:0] lw;
    lw = {D3, D2, D1, D0};
    @(negedge clk);
    address_i = 32'h0000_0080; line_i = lw; write_i = 1'b1;
    @(posedge clk); #1;
    write_i = 1'b0; c0 = resp_cnt;
    resp_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resp_i = 1'b0;
    n_cmp++; if (burst_o !== D2) begin n_bad++; $display("FAIL midwrite_beat2 got %h want %h", burst_o, D2); end
    reset = 1'b1;
    #1;
    n_cmp++; if (write_o !== 1'b0) begin n_bad++; $display("FAIL midreset_write_o got %b want 0", write_o); end
    n_cmp++; if (burst_o !== '0) begin n_bad++; $display("FAIL midreset_burst_o got %h want 0", burst_o); end
    n_cmp++; if (resp_o !== 1'b0) begin n_bad++; $display("FAIL midreset_resp_o got %b want 0", resp_o); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if ((resp_cnt - c0) !== 0) begin n_bad++; $display("FAIL midreset_no_resp got %0d want 0", resp_cnt - c0); end
    drive_read(32'h0000_00C7, {A2, A3, A0, A1}, 16'h000F, 4, lat, pulses, held, rd_done);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL postreset_latency got %0d want 5", lat); end
    n_cmp++; if (line_o !== {A2, A3, A0, A1}) begin n_bad++; $display("FAIL postreset_line got %h want %h", line_o, {A2, A3, A0, A1}); end
    n_cmp++; if (address_o !== 32'h0000_00C0) begin n_bad++; $display("FAIL postreset_address got %h want 000000c0", address_o); end
  endtask

  task automatic test_wide();
    logic [WLW-1:0] wl;
    int req, lat, c0;
    wl = {128'h3333_3333_0000_0000_3333_3333_FFFF_0003, 128'h2222_2222_0000_0000_2222_2222_FFFF_0002,
          128'h1111_1111_0000_0000_1111_1111_FFFF_0001, 128'h0000_0000_ABCD_0000_0000_0000_FFFF_0000};
    @(negedge clk);
    w_address_i = 32'h1234_5678; w_read_i = 1'b1;
    @(posedge clk); #1;
    w_read_i = 1'b0; req = cyc; c0 = w_resp_cnt;
    for (int i = 0; i < 4; i++) begin
      w_resp_i = 1'b1; w_burst_i = wl[i*WBW +: WBW];
      @(posedge clk); #1;
    end
    w_resp_i = 1'b0; w_burst_i = '0;
    @(negedge clk);
    lat = (w_resp_o === 1'b1) ? (cyc - req + 1) : -1;
    @(posedge clk); #2;
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL wide_latency got %0d want 5", lat); end
    n_cmp++; if (w_address_o !== 32'h1234_5640) begin n_bad++; $display("FAIL wide_address got %h want 12345640", w_address_o); end
    n_cmp++; if (w_line_o !== wl) begin n_bad++; $display("FAIL wide_line got %h want %h", w_line_o, wl); end
    n_cmp++; if ((w_resp_cnt - c0) !== 1) begin n_bad++; $display("FAIL wide_pulses got %0d want 1", w_resp_cnt - c0); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_stalled_read();
    test_stalled_write();
    test_read_write_together();
    test_reset_mid_write();
    test_wide();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
